// File: rtl/bram_dp_model_pipe.sv
// bram_dp_model_pipe: single-clock true dual-port byte-write memory model with
// a RD_LAT-deep read pipeline per port, per-port read mode (READ_FIRST /
// WRITE_FIRST / NO_CHANGE) and same-address collision reporting.
// Optional: define BRAM_COLL_CNT_EN to add a 16-bit saturating collision
// counter output (coll_cnt).
module bram_dp_model_pipe #(
    parameter int AWIDTH    = 14,
    parameter int CWIDTH    = 8,
    parameter int CCOUNT    = 128,
    parameter int DWIDTH    = 1024,
    parameter int RD_LAT    = 1,
    parameter int RD_MODE_A = 0,
    parameter int RD_MODE_B = 0
) (
    input  logic              bram_clk,
    input  logic              bram_rst,
    input  logic              bram_en_a,
    input  logic [AWIDTH-1:0] bram_addr_a,
    input  logic [CCOUNT-1:0] bram_we_a,
    input  logic [DWIDTH-1:0] bram_wrdata_a,
    output logic [DWIDTH-1:0] bram_rddata_a,
    output logic              bram_rdvalid_a,
    input  logic              bram_en_b,
    input  logic [AWIDTH-1:0] bram_addr_b,
    input  logic [CCOUNT-1:0] bram_we_b,
    input  logic [DWIDTH-1:0] bram_wrdata_b,
    output logic [DWIDTH-1:0] bram_rddata_b,
    output logic              bram_rdvalid_b,
    output logic              coll
`ifdef BRAM_COLL_CNT_EN
    ,
    output logic [15:0]       coll_cnt
`endif
);

    localparam int DEPTH           = 1 << AWIDTH;
    localparam int MODE_WRITE_FIRST = 1;
    localparam int MODE_NO_CHANGE   = 2;

    if (DWIDTH != CWIDTH * CCOUNT) begin : g_chk_dwidth
        $error("DWIDTH must equal CWIDTH*CCOUNT");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_rd_lat
        $error("RD_LAT must be in 1..4");
    end
    if (RD_MODE_A < 0 || RD_MODE_A > 2 || RD_MODE_B < 0 || RD_MODE_B > 2) begin : g_chk_mode
        $error("RD_MODE_A/RD_MODE_B must be 0, 1 or 2");
    end

    logic [DWIDTH-1:0] mem [DEPTH];

    // Ops are ignored entirely while reset is high.
    logic acc_a, acc_b, coll_hit;
    assign acc_a    = bram_en_a && !bram_rst;
    assign acc_b    = bram_en_b && !bram_rst;
    assign coll_hit = acc_a && acc_b && (bram_addr_a == bram_addr_b)
                      && ((|bram_we_a) || (|bram_we_b));

    // Per-port views gathered into arrays so both read paths share one generate body.
    logic              p_acc  [2];
    logic [CCOUNT-1:0] p_we   [2];
    logic [DWIDTH-1:0] p_wd   [2];
    logic [DWIDTH-1:0] p_old  [2];
    logic [DWIDTH-1:0] p_rd   [2];
    logic              p_rv   [2];

    assign p_acc[0] = acc_a;
    assign p_acc[1] = acc_b;
    assign p_we[0]  = bram_we_a;
    assign p_we[1]  = bram_we_b;
    assign p_wd[0]  = bram_wrdata_a;
    assign p_wd[1]  = bram_wrdata_b;
    assign p_old[0] = mem[bram_addr_a];
    assign p_old[1] = mem[bram_addr_b];

    // Byte-lane write; port B first, port A second so A owns overlapping lanes.
    // NOTE: the array has no reset branch -- contents survive bram_rst, and the
    // later non-blocking assignment (port A) wins when both ports hit one lane.
    always_ff @(posedge bram_clk) begin
        for (int i = 0; i < CCOUNT; i++) begin
            if (acc_b && bram_we_b[i])
                mem[bram_addr_b][i*CWIDTH +: CWIDTH] <= bram_wrdata_b[i*CWIDTH +: CWIDTH];
            if (acc_a && bram_we_a[i])
                mem[bram_addr_a][i*CWIDTH +: CWIDTH] <= bram_wrdata_a[i*CWIDTH +: CWIDTH];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int MODE = (p == 0) ? RD_MODE_A : RD_MODE_B;

        logic              issue;
        logic [DWIDTH-1:0] view;
        logic [RD_LAT:1]   vld;
        logic [DWIDTH-1:0] dat [1:RD_LAT];

        // Select this port's own view of the word; the other port's write is never visible.
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        always_comb begin
            view  = p_old[p];
            issue = p_acc[p] && !((MODE == MODE_NO_CHANGE) && (|p_we[p]));
            if (MODE == MODE_WRITE_FIRST) begin
                for (int i = 0; i < CCOUNT; i++) begin
                    if (p_we[p][i])
                        view[i*CWIDTH +: CWIDTH] = p_wd[p][i*CWIDTH +: CWIDTH];
                end
            end
        end

        // Read shift pipeline; data stages only load behind a valid so rddata holds otherwise.
        // NOTE: sequential state uses non-blocking assignments so stages shift in lockstep.
        always_ff @(posedge bram_clk) begin
            if (bram_rst) begin
                vld <= '0;
                for (int k = 1; k <= RD_LAT; k++) dat[k] <= '0;
            end else begin
                vld[1] <= issue;
                if (issue) dat[1] <= view;
                for (int k = 2; k <= RD_LAT; k++) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) dat[k] <= dat[k-1];
                end
            end
        end

        assign p_rd[p] = dat[RD_LAT];
        assign p_rv[p] = vld[RD_LAT];
    end

    assign bram_rddata_a  = p_rd[0];
    assign bram_rdvalid_a = p_rv[0];
    assign bram_rddata_b  = p_rd[1];
    assign bram_rdvalid_b = p_rv[1];

    // Collision flag, one-cycle pulse after the colliding op is accepted.
    always_ff @(posedge bram_clk) begin
        if (bram_rst) coll <= 1'b0;
        else          coll <= coll_hit;
    end

`ifdef BRAM_COLL_CNT_EN
    // Saturating collision counter, advances on the edge that raises coll.
    always_ff @(posedge bram_clk) begin
        if (bram_rst)                              coll_cnt <= 16'd0;
        else if (coll_hit && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bram_dp_model_pipe.sv
// Directed bench for bram_dp_model_pipe with two instances:
//   u_dut0: RD_LAT=3, port A READ_FIRST, port B WRITE_FIRST
//   u_dut1: RD_LAT=4, port A NO_CHANGE (port B unused)
module tb_bram_dp_model_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        d0_rst, d0_en_a, d0_en_b, d0_rv_a, d0_rv_b, d0_coll;
    logic [3:0]  d0_addr_a, d0_addr_b, d0_we_a, d0_we_b;
    logic [31:0] d0_wd_a, d0_wd_b, d0_rd_a, d0_rd_b;
    logic        d1_rst, d1_en_a, d1_en_b, d1_rv_a, d1_rv_b, d1_coll;
    logic [3:0]  d1_addr_a, d1_addr_b, d1_we_a, d1_we_b;
    logic [31:0] d1_wd_a, d1_wd_b, d1_rd_a, d1_rd_b;
`ifdef BRAM_COLL_CNT_EN
    logic [15:0] d0_cnt, d1_cnt;
`endif

    bram_dp_model_pipe #(
        .AWIDTH(4), .CWIDTH(8), .CCOUNT(4), .DWIDTH(32),
        .RD_LAT(3), .RD_MODE_A(0), .RD_MODE_B(1)
    ) u_dut0 (
        .bram_clk(clk), .bram_rst(d0_rst),
        .bram_en_a(d0_en_a), .bram_addr_a(d0_addr_a), .bram_we_a(d0_we_a),
        .bram_wrdata_a(d0_wd_a), .bram_rddata_a(d0_rd_a), .bram_rdvalid_a(d0_rv_a),
        .bram_en_b(d0_en_b), .bram_addr_b(d0_addr_b), .bram_we_b(d0_we_b),
        .bram_wrdata_b(d0_wd_b), .bram_rddata_b(d0_rd_b), .bram_rdvalid_b(d0_rv_b),
        .coll(d0_coll)
`ifdef BRAM_COLL_CNT_EN
        , .coll_cnt(d0_cnt)
`endif
    );

    bram_dp_model_pipe #(
        .AWIDTH(4), .CWIDTH(8), .CCOUNT(4), .DWIDTH(32),
        .RD_LAT(4), .RD_MODE_A(2), .RD_MODE_B(0)
    ) u_dut1 (
        .bram_clk(clk), .bram_rst(d1_rst),
        .bram_en_a(d1_en_a), .bram_addr_a(d1_addr_a), .bram_we_a(d1_we_a),
        .bram_wrdata_a(d1_wd_a), .bram_rddata_a(d1_rd_a), .bram_rdvalid_a(d1_rv_a),
        .bram_en_b(d1_en_b), .bram_addr_b(d1_addr_b), .bram_we_b(d1_we_b),
        .bram_wrdata_b(d1_wd_b), .bram_rddata_b(d1_rd_b), .bram_rdvalid_b(d1_rv_b),
        .coll(d1_coll)
`ifdef BRAM_COLL_CNT_EN
        , .coll_cnt(d1_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a0(input logic en, input logic [3:0] addr, input logic [3:0] we,
                      input logic [31:0] wd);
        d0_en_a = en; d0_addr_a = addr; d0_we_a = we; d0_wd_a = wd;
    endtask

    task automatic b0(input logic en, input logic [3:0] addr, input logic [3:0] we,
                      input logic [31:0] wd);
        d0_en_b = en; d0_addr_b = addr; d0_we_b = we; d0_wd_b = wd;
    endtask

    task automatic a1(input logic en, input logic [3:0] addr, input logic [3:0] we,
                      input logic [31:0] wd);
        d1_en_a = en; d1_addr_a = addr; d1_we_a = we; d1_wd_a = wd;
    endtask

    int pulses;

    initial begin
        d0_rst = 1'b1; d1_rst = 1'b1;
        a0(0, 0, 0, 0); b0(0, 0, 0, 0); a1(0, 0, 0, 0);
        d1_en_b = 1'b0; d1_addr_b = '0; d1_we_b = '0; d1_wd_b = '0;
        tick(); tick();
        d0_rst = 1'b0; d1_rst = 1'b0;

        // Reset state
        check("rst_rd_a",  d0_rd_a, 32'h0);
        check("rst_rv_a",  32'(d0_rv_a), 32'h0);
        check("rst_rd_b",  d0_rd_b, 32'h0);
        check("rst_rv_b",  32'(d0_rv_b), 32'h0);
        check("rst_coll",  32'(d0_coll), 32'h0);
        check("rst_rv_d1", 32'(d1_rv_a), 32'h0);
`ifdef BRAM_COLL_CNT_EN
        check("rst_cnt", 32'(d0_cnt), 32'h0);
`endif

        // Latency: two writes, flush, then back-to-back reads of 5 and 6
        a0(1, 5, 4'hF, 32'hDEADBEEF); tick();
        a0(1, 6, 4'hF, 32'h01020304); tick();
        a0(0, 0, 0, 0); repeat (4) tick();
        a0(1, 5, 0, 0); tick();
        a0(1, 6, 0, 0); tick();
        a0(0, 0, 0, 0);
        check("lat_early_rv", 32'(d0_rv_a), 32'h0);
        tick();
        check("lat3_rv", 32'(d0_rv_a), 32'h1);
        check("lat3_rd", d0_rd_a, 32'hDEADBEEF);
        tick();
        check("lat4_rv", 32'(d0_rv_a), 32'h1);
        check("lat4_rd", d0_rd_a, 32'h01020304);
        tick();
        check("idle_rv", 32'(d0_rv_a), 32'h0);
        check("idle_hold", d0_rd_a, 32'h01020304);

        // Byte lanes: B write with we=0101 onto 11223344 (B is WRITE_FIRST)
        a0(1, 2, 4'hF, 32'h11223344); tick();
        a0(0, 0, 0, 0);
        b0(1, 2, 4'b0101, 32'hAABBCCDD); tick();
        b0(0, 0, 0, 0); tick(); tick();
        check("lane_wf_rv", 32'(d0_rv_b), 32'h1);
        check("lane_wf_rd", d0_rd_b, 32'h11BB33DD);
        a0(1, 2, 0, 0); tick();
        a0(0, 0, 0, 0); tick(); tick();
        check("lane_rb_rv", 32'(d0_rv_a), 32'h1);
        check("lane_rb_rd", d0_rd_a, 32'h11BB33DD);

        // READ_FIRST on port A
        a0(1, 3, 4'hF, 32'h0); tick();
        a0(1, 3, 4'hF, 32'h12345678); tick();
        a0(0, 0, 0, 0); tick(); tick();
        check("rf_rv", 32'(d0_rv_a), 32'h1);
        check("rf_rd", d0_rd_a, 32'h0);

        // WRITE_FIRST on port B
        a0(1, 3, 4'hF, 32'h0); tick();
        a0(0, 0, 0, 0);
        b0(1, 3, 4'hF, 32'h12345678); tick();
        b0(0, 0, 0, 0); tick(); tick();
        check("wf_rv", 32'(d0_rv_b), 32'h1);
        check("wf_rd", d0_rd_b, 32'h12345678);

        // NO_CHANGE on u_dut1 port A: establish prior rddata, then write
        a1(1, 4, 4'hF, 32'hCAFEF00D); tick();
        a1(1, 4, 0, 0); tick();
        a1(0, 0, 0, 0); tick(); tick(); tick();
        check("nc_prior_rv", 32'(d1_rv_a), 32'h1);
        check("nc_prior_rd", d1_rd_a, 32'hCAFEF00D);
        a1(1, 3, 4'hF, 32'h0); tick();
        a1(1, 3, 4'hF, 32'h12345678); tick();
        a1(0, 0, 0, 0);
        pulses = 0;
        repeat (5) begin tick(); pulses += int'(d1_rv_a); end
        check("nc_no_rv", 32'(pulses), 32'h0);
        check("nc_hold", d1_rd_a, 32'hCAFEF00D);

        // Collision on address 7
        a0(1, 7, 4'hF, 32'h0); tick();
        a0(0, 0, 0, 0); repeat (4) tick();
        check("single_port_no_coll", 32'(d0_coll), 32'h0);
        a0(1, 7, 4'b0011, 32'hAAAAAAAA);
        b0(1, 7, 4'b0110, 32'hBBBBBBBB); tick();
        a0(0, 0, 0, 0); b0(0, 0, 0, 0);
        check("coll_pulse", 32'(d0_coll), 32'h1);
`ifdef BRAM_COLL_CNT_EN
        check("coll_cnt_1", 32'(d0_cnt), 32'h1);
`endif
        tick();
        check("coll_once", 32'(d0_coll), 32'h0);
        tick();
        check("coll_rf_view", d0_rd_a, 32'h0);
        check("coll_wf_view", d0_rd_b, 32'h00BBBB00);
        a0(1, 7, 0, 0); tick();
        a0(0, 0, 0, 0); tick(); tick();
        check("coll_merge", d0_rd_a, 32'h00BBAAAA);
        a0(1, 7, 0, 0); b0(1, 7, 0, 0); tick();
        a0(0, 0, 0, 0); b0(0, 0, 0, 0);
        check("rr_no_coll", 32'(d0_coll), 32'h0);

        // Reset mid-stream on u_dut1 (RD_LAT=4)
        a1(1, 3, 0, 0); tick();
        a1(1, 4, 0, 0); tick();
        a1(1, 3, 0, 0); tick();
        a1(0, 0, 0, 0); d1_rst = 1'b1; tick();
        d1_rst = 1'b0;
        check("mid_rst_rd", d1_rd_a, 32'h0);
        check("mid_rst_rv", 32'(d1_rv_a), 32'h0);
        pulses = 0;
        repeat (8) begin tick(); pulses += int'(d1_rv_a); end
        check("mid_rst_no_rv", 32'(pulses), 32'h0);
        a1(1, 3, 0, 0); tick();
        a1(0, 0, 0, 0); tick(); tick(); tick();
        check("mid_rst_keep_rv", 32'(d1_rv_a), 32'h1);
        check("mid_rst_keep_rd", d1_rd_a, 32'h12345678);

        // Writes issued during reset must not land
        d0_rst = 1'b1; a0(1, 2, 4'hF, 32'hFFFFFFFF); tick();
        d0_rst = 1'b0; a0(1, 2, 0, 0); tick();
        a0(0, 0, 0, 0); tick(); tick();
        check("rst_blocks_wr", d0_rd_a, 32'h11BB33DD);

`ifdef BRAM_COLL_CNT_EN
        // Saturation of the collision counter
        a0(1, 0, 4'h1, 32'h0); b0(1, 0, 4'h0, 32'h0);
        repeat (65540) @(posedge clk);
        #1;
        a0(0, 0, 0, 0); b0(0, 0, 0, 0);
        check("cnt_sat", 32'(d0_cnt), 32'h0000FFFF);
        d0_rst = 1'b1; tick();
        d0_rst = 1'b0;
        check("cnt_clr", 32'(d0_cnt), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
